// File: rtl/coloring_gen.sv
// Pseudo-random colour stream source that never breaks the triple or 0/1-adjacency rules.
// Optional COLORING_GEN_SEED_EN adds a seed port that reloads the LFSR on every accepted start.
module coloring_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       ready,
`ifdef COLORING_GEN_SEED_EN
    input  logic [7:0] seed,
`endif
    output logic [1:0] color,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state_r;
    logic [3:0] hist_r;
    logic [7:0] lfsr_r;
    logic [7:0] remaining_r;
    logic [1:0] color_r;
    logic       valid_r;
    logic       busy_r;
    logic       done_r;

    logic       accept_s;
    logic [3:0] hist_acc_s;
    logic [7:0] lfsr_acc_s;
    logic [7:0] lfsr_start_s;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        lfsr_step = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic is_legal(input logic [3:0] h, input logic [1:0] c);
        logic [1:0] p2;
        logic [1:0] p1;
        p2 = h[3:2];
        p1 = h[1:0];
        is_legal = !((p2 == p1) && (p1 == c)) &&
                   ({p1, c} != 4'b0001) && ({p1, c} != 4'b0100);
    endfunction

    function automatic logic [1:0] pick(input logic [3:0] h, input logic [7:0] l);
        logic [1:0] c0;
        c0 = l[1:0];
        if (is_legal(h, c0))
            pick = c0;
        else if (is_legal(h, c0 + 2'd1))
            pick = c0 + 2'd1;
        else if (is_legal(h, c0 + 2'd2))
            pick = c0 + 2'd2;
        else
            pick = c0 + 2'd3;
    endfunction

    // Next history/LFSR on an accept, and the LFSR value loaded by a start.
    always_comb begin
        accept_s   = valid_r && ready;
        hist_acc_s = {hist_r[1:0], color_r};
        lfsr_acc_s = lfsr_step(lfsr_r);
`ifdef COLORING_GEN_SEED_EN
        lfsr_start_s = (seed == 8'h00) ? 8'hA5 : seed;
`else
        lfsr_start_s = lfsr_r;
`endif
    end

    // Sequencer: colour is precomputed from the next hist/lfsr so it is registered and stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            hist_r      <= 4'hF;
            lfsr_r      <= 8'hA5;
            remaining_r <= 8'd0;
            color_r     <= 2'b00;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        hist_r      <= 4'hF;
                        lfsr_r      <= lfsr_start_s;
                        remaining_r <= len;
                        if (len != 8'd0) begin
                            state_r <= RUN;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                            color_r <= pick(4'hF, lfsr_start_s);
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        hist_r      <= hist_acc_s;
                        lfsr_r      <= lfsr_acc_s;
                        remaining_r <= remaining_r - 8'd1;
                        if (remaining_r == 8'd1) begin
                            state_r <= DONE;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            color_r <= 2'b00;
                        end else begin
                            color_r <= pick(hist_acc_s, lfsr_acc_s);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    color_r <= 2'b00;
                end
            endcase
        end
    end

    assign color = color_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_coloring_gen.sv
// Directed and table-driven bench for coloring_gen; long run checks the colouring rules on the stream.
module tb_coloring_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       ready;
    logic [1:0] color;
    logic       valid;
    logic       busy;
    logic       done;
`ifdef COLORING_GEN_SEED_EN
    logic [7:0] seed;
`endif

    int checks;
    int errors;

    coloring_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .ready (ready),
`ifdef COLORING_GEN_SEED_EN
        .seed  (seed),
`endif
        .color (color),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       rd;
        logic       ev;
        logic [1:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t       tbl[10];
    logic [1:0] exp10[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        len   = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] p1, p2, prev_color;
        logic       stall, done_seen;
        int         hist_n, accepts, cyc;

        checks = 0;
        errors = 0;
`ifdef COLORING_GEN_SEED_EN
        seed = 8'h00;
`endif
        // backpressure/start-ignore table, colours start 1,2,1 after reset
        tbl[0] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        // LFSR A5,4A,95,2A,54,A9,53,A7,4E,9D steered through the rules
        exp10[0] = 2'd1; exp10[1] = 2'd2; exp10[2] = 2'd1; exp10[3] = 2'd2; exp10[4] = 2'd0;
        exp10[5] = 2'd2; exp10[6] = 2'd3; exp10[7] = 2'd3; exp10[8] = 2'd2; exp10[9] = 2'd1;

        do_reset();
        chk("reset_color", color, 2'd0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // len=2 with ready held high
        start = 1'b1; len = 8'd2; ready = 1'b1;
        tick();
        start = 1'b0;
        chk("len2_c1", color, 2'd1);
        chk("len2_v1", valid, 1'b1);
        chk("len2_b1", busy, 1'b1);
        tick();
        chk("len2_c2", color, 2'd2);
        chk("len2_v2", valid, 1'b1);
        tick();
        chk("len2_done", done, 1'b1);
        chk("len2_valid_off", valid, 1'b0);
        chk("len2_busy_off", busy, 1'b0);
        tick();
        chk("len2_done_pulse", done, 1'b0);

        // table-driven backpressure run, len=3, starts in RUN/DONE ignored
        do_reset();
        start = 1'b1; len = 8'd3; ready = 1'b0;
        tick();
        start = 1'b0; len = 8'd7;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].ev);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
            if (tbl[i].ev) chk($sformatf("tbl%0d_color", i), color, tbl[i].ec);
            start = tbl[i].st;
            ready = tbl[i].rd;
            tick();
        end

        // len=0: immediate done, no colours
        do_reset();
        start = 1'b1; len = 8'd0; ready = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_valid", valid, 1'b0);
        chk("len0_busy", busy, 1'b0);
        tick();
        chk("len0_done_off", done, 1'b0);
        chk("len0_valid2", valid, 1'b0);

        // len=20, reset after 10 accepts, then restart
        do_reset();
        start = 1'b1; len = 8'd20; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("seq_c%0d", i), color, exp10[i]);
            chk($sformatf("seq_v%0d", i), valid, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_color", color, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_done", done, 1'b0);
            chk("mid_rst_idle", valid, 1'b0);
        end
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        chk("restart_c1", color, 2'd1);
        tick();
        chk("restart_c2", color, 2'd2);
        tick();
        chk("restart_done", done, 1'b1);

        // len=255 with random ready: count accepts, check rules and stability
        do_reset();
        start = 1'b1; len = 8'd255; ready = 1'b0;
        tick();
        start = 1'b0; len = 8'd0;
        p1 = 2'd3; p2 = 2'd3; hist_n = 0; accepts = 0;
        stall = 1'b0; prev_color = 2'd0; done_seen = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (stall) begin
                chk("bp_valid_hold", valid, 1'b1);
                chk("bp_color_hold", color, prev_color);
            end
            if (valid) chk("run_busy", busy, 1'b1);
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                if (hist_n >= 1)
                    chk("rule_adj01", ((p1 == 2'd0 && color == 2'd1) || (p1 == 2'd1 && color == 2'd0)), 1'b0);
                if (hist_n >= 2)
                    chk("rule_triple", (p2 == p1 && p1 == color), 1'b0);
                p2 = p1;
                p1 = color;
                hist_n++;
                accepts++;
            end
            stall = valid && !ready;
            prev_color = color;
            tick();
        end
        chk("long_done_seen", done_seen, 1'b1);
        chk("long_accepts", accepts, 255);
        chk("long_valid_off", valid, 1'b0);
        ready = 1'b0;
        tick();
        chk("long_done_pulse", done, 1'b0);

`ifdef COLORING_GEN_SEED_EN
        // seed 0 falls back to A5; seed 3 hits the triple rule against hist F
        do_reset();
        seed = 8'h00; start = 1'b1; len = 8'd2; ready = 1'b1;
        tick();
        start = 1'b0;
        chk("seed0_c1", color, 2'd1);
        tick();
        chk("seed0_c2", color, 2'd2);
        tick();
        tick();
        seed = 8'h03; start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        chk("seed3_c1", color, 2'd0);
        chk("seed3_v1", valid, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
